// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared alu32 datapath.
// A granted request drives the ALU operands for a per-opcode latency, then the
// ALU outputs are captured and returned on a single tagged response channel.
module alu_req_arbiter #(
    parameter int unsigned LAT_FAST = 1,
    parameter int unsigned LAT_SLOW = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_mul_hi,
    input  logic [31:0] alu_mul_lo,
    input  logic [3:0]  alu_nzvc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [31:0] rsp_mul_hi,
    output logic [31:0] rsp_mul_lo,
    output logic [3:0]  rsp_nzvc,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] RESP = 2'b10;

    localparam logic [CNT_W-1:0] CNT_FAST = CNT_W'(LAT_FAST);
    localparam logic [CNT_W-1:0] CNT_SLOW = CNT_W'(LAT_SLOW);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;

    logic             grant_id;
    logic             accept;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic [3:0]       sel_op;
    logic             sel_illegal;
    logic             sel_slow;

    assign busy = (state != IDLE);

    // Round-robin grant and payload select; ready only in IDLE and never during reset.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
        accept      = !rst && (state == IDLE) && (req0_valid || req1_valid);
        req0_ready  = accept && !grant_id;
        req1_ready  = accept && grant_id;
        sel_a       = grant_id ? req1_a  : req0_a;
        sel_b       = grant_id ? req1_b  : req0_b;
        sel_op      = grant_id ? req1_op : req0_op;
        sel_illegal = (sel_op[3:2] == 2'b11);
        sel_slow    = (sel_op == 4'b0010) || (sel_op == 4'b0011);
    end

    // Control FSM: accept, hold ALU inputs for the op latency, capture, hand back the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_mul_hi <= '0;
            rsp_mul_lo <= '0;
            rsp_nzvc   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= grant_id;
                        rsp_id     <= grant_id;
                        if (sel_illegal) begin
                            // Illegal opcodes never reach the ALU; answer with an error straight away.
                            rsp_result <= '0;
                            rsp_mul_hi <= '0;
                            rsp_mul_lo <= '0;
                            rsp_nzvc   <= '0;
                            rsp_err    <= 1'b1;
                            rsp_valid  <= 1'b1;
                            state      <= RESP;
                        end else begin
                            alu_a  <= sel_a;
                            alu_b  <= sel_b;
                            alu_op <= sel_op;
                            cnt    <= sel_slow ? CNT_SLOW : CNT_FAST;
                            state  <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        rsp_result <= alu_result;
                        rsp_mul_hi <= alu_mul_hi;
                        rsp_mul_lo <= alu_mul_lo;
                        rsp_nzvc   <= alu_nzvc;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a stand-in alu32, a table of directed ops,
// hand-written multi-cycle sequences and a randomized run against a
// transaction-level model of arbitration, latency and response content.
module tb_alu_req_arbiter;

    localparam int unsigned LAT_FAST = 1;
    localparam int unsigned LAT_SLOW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b, alu_result, alu_mul_hi, alu_mul_lo;
    logic [3:0]  alu_op, alu_nzvc;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [31:0] rsp_result, rsp_mul_hi, rsp_mul_lo;
    logic [3:0]  rsp_nzvc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  nzvc;
    } alu_out_t;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] er;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic [3:0]  enz;
        logic        eerr;
        int          elat;
    } vec_t;

    typedef struct {
        int          id;
        logic        legal;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        alu_out_t    o;
        int          lat;
        int          acc;
    } flight_t;

    // Behavioural alu32 stand-in: opcode 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND,
    // 5 OR, 6 XOR, 7 NOT, 8 SHL, 9 SHR, 10 SRA, 11 COMP (flags of a-b, result a<b).
    function automatic alu_out_t alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        alu_out_t    o;
        logic [32:0] s;
        logic [63:0] p;
        logic [31:0] d;
        o = '0;
        case (op)
            4'h0: begin
                s = {1'b0, a} + {1'b0, b};
                o.result = s[31:0];
                o.nzvc = {s[31], s[31:0] == 32'd0, (a[31] == b[31]) && (s[31] != a[31]), s[32]};
            end
            4'h1: begin
                d = a - b;
                o.result = d;
                o.nzvc = {d[31], d == 32'd0, (a[31] != b[31]) && (d[31] != a[31]), a < b};
            end
            4'h2: begin
                p = {32'd0, a} * {32'd0, b};
                o.result = p[31:0];
                o.hi = p[63:32];
                o.lo = p[31:0];
                o.nzvc = {p[31], p[31:0] == 32'd0, 2'b00};
            end
            4'h3: o.result = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'h4: o.result = a & b;
            4'h5: o.result = a | b;
            4'h6: o.result = a ^ b;
            4'h7: o.result = ~a;
            4'h8: o.result = a << b[4:0];
            4'h9: o.result = a >> b[4:0];
            4'hA: o.result = $signed(a) >>> b[4:0];
            4'hB: begin
                d = a - b;
                o.result = {31'd0, a < b};
                o.nzvc = {d[31], d == 32'd0, (a[31] != b[31]) && (d[31] != a[31]), a < b};
            end
            default: begin
                o.result = 32'hA5A5_A5A5;
                o.nzvc = 4'hF;
            end
        endcase
        if (op >= 4'h3 && op <= 4'hA) o.nzvc = {o.result[31], o.result == 32'd0, 2'b00};
        return o;
    endfunction

    alu_out_t ao;
    assign ao         = alu_fn(alu_a, alu_b, alu_op);
    assign alu_result = ao.result;
    assign alu_mul_hi = ao.hi;
    assign alu_mul_lo = ao.lo;
    assign alu_nzvc   = ao.nzvc;

    alu_req_arbiter #(
        .LAT_FAST(LAT_FAST),
        .LAT_SLOW(LAT_SLOW),
        .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_mul_hi(alu_mul_hi), .alu_mul_lo(alu_mul_lo), .alu_nzvc(alu_nzvc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_mul_hi(rsp_mul_hi), .rsp_mul_lo(rsp_mul_lo),
        .rsp_nzvc(rsp_nzvc), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected ALU port contents: last legal op issued since reset.
    logic [31:0] ea, eb;
    logic [3:0]  eop;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_mul_hi,
                     rsp_mul_lo, rsp_nzvc, rsp_err, busy, req0_ready, req1_ready});
    endfunction

    function automatic logic [127:0] rsp_pack();
        return 128'({rsp_id, rsp_result, rsp_mul_hi, rsp_mul_lo, rsp_nzvc, rsp_err});
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        step();
        rst = 1'b0;
        ea = '0;
        eb = '0;
        eop = '0;
    endtask

    task automatic wait_ready(input int id);
        int n = 0;
        #1;
        while (!(id == 1 ? req1_ready : req0_ready) && n < 20) begin
            step();
            n++;
        end
        if (!(id == 1 ? req1_ready : req0_ready)) timeout("wait_ready");
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        if (!rsp_valid) timeout("wait_rsp");
    endtask

    task automatic drain(input logic id, input logic [31:0] res);
        wait_rsp();
        chk("drain_id_result", 128'({rsp_id, rsp_result}), 128'({id, res}));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    // Apply one directed op from a single requester and check latency, content and ALU ports.
    task automatic run_vec(input vec_t v);
        int edges;
        if (v.id == 1) begin
            req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_op = v.op;
        end else begin
            req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_op = v.op;
        end
        wait_ready(v.id);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!v.eerr) begin
            ea = v.a; eb = v.b; eop = v.op;
        end
        edges = 0;
        while (!rsp_valid && edges < 20) begin
            chk("exec_alu_ports", 128'({alu_a, alu_b, alu_op, busy}), 128'({ea, eb, eop, 1'b1}));
            step();
            edges++;
        end
        if (!rsp_valid) timeout("vec_rsp");
        chk("vec_latency", 128'(edges), 128'(v.elat));
        chk("vec_rsp", rsp_pack(), 128'({v.id[0], v.er, v.ehi, v.elo, v.enz, v.eerr}));
        chk("vec_alu_ports", 128'({alu_a, alu_b, alu_op}), 128'({ea, eb, eop}));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("vec_rsp_drop", 128'({rsp_valid, busy}), 128'(0));
    endtask

    vec_t    vt[12];
    flight_t cur;

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(3))
            0:       return 32'($urandom_range(20));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // legal ops: rsp_valid shows up LAT clock edges after the accept edge;
        // illegal ops: rsp_valid is already up right after the accept edge.
        vt[0]  = '{0, 32'd10,        32'd5,         4'h0, 32'd15,        32'd0, 32'd0,         4'b0000, 1'b0, 1};
        vt[1]  = '{1, 32'd10,        32'd5,         4'h2, 32'd50,        32'd0, 32'd50,        4'b0000, 1'b0, 4};
        vt[2]  = '{0, 32'd10,        32'd5,         4'h1, 32'd5,         32'd0, 32'd0,         4'b0000, 1'b0, 1};
        vt[3]  = '{1, 32'hFF00FF00,  32'h00FF00FF,  4'h6, 32'hFFFFFFFF,  32'd0, 32'd0,         4'b1000, 1'b0, 1};
        vt[4]  = '{0, 32'd1,         32'd2,         4'hE, 32'd0,         32'd0, 32'd0,         4'b0000, 1'b1, 0};
        vt[5]  = '{1, 32'd15,        32'd3,         4'h3, 32'd5,         32'd0, 32'd0,         4'b0000, 1'b0, 4};
        vt[6]  = '{0, 32'h7FFFFFFF,  32'd1,         4'h0, 32'h80000000,  32'd0, 32'd0,         4'b1010, 1'b0, 1};
        vt[7]  = '{1, 32'hFFFFFFFF,  32'd1,         4'h0, 32'd0,         32'd0, 32'd0,         4'b0101, 1'b0, 1};
        vt[8]  = '{0, 32'hFFFFFFFF,  32'd2,         4'h2, 32'hFFFFFFFE,  32'd1, 32'hFFFFFFFE,  4'b1000, 1'b0, 4};
        vt[9]  = '{1, 32'h0F0F0F0F,  32'h00FF00FF,  4'h4, 32'h000F000F,  32'd0, 32'd0,         4'b0000, 1'b0, 1};
        vt[10] = '{1, 32'd3,         32'd4,         4'hC, 32'd0,         32'd0, 32'd0,         4'b0000, 1'b1, 0};
        vt[11] = '{0, 32'd5,         32'd7,         4'hB, 32'd1,         32'd0, 32'd0,         4'b1001, 1'b0, 1};

        // Reset with both requesters asserting: everything must read zero.
        rst = 1'b1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_op = '0;
        step();
        step();
        chk("reset_outputs", all_outs(), 128'(0));
        do_reset();

        for (int i = 0; i < 12; i++) run_vec(vt[i]);

        // COMP 5 vs 7 with the consumer stalling; req1 waits behind it.
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 4'hB;
        wait_ready(0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_op = 4'h0;
        #1;
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp", rsp_pack(), 128'({1'b0, 32'd1, 32'd0, 32'd0, 4'b1001, 1'b0}));
            chk("stall_busy_ready", 128'({rsp_valid, busy, req1_ready}), 128'(3'b110));
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("stall_drop_then_idle", 128'({rsp_valid, busy, req1_ready}), 128'(3'b001));
        step();
        req1_valid = 1'b0;
        drain(1'b1, 32'd3);

        // Both valid continuously: grants alternate starting with req0.
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd5; req0_op = 4'h1;
        req1_valid = 1'b1; req1_a = 32'hFF00FF00; req1_b = 32'h00FF00FF; req1_op = 4'h6;
        rsp_ready = 1'b1;
        #1;
        for (int n = 0; n < 4; n++) begin
            int k = 0;
            while (!(req0_ready || req1_ready) && k < 20) begin
                step();
                k++;
            end
            chk("alt_grant", 128'({req0_ready, req1_ready}), 128'((n % 2 == 1) ? 2'b01 : 2'b10));
            step();
            wait_rsp();
            chk("alt_rsp", 128'({rsp_id, rsp_result}),
                128'((n % 2 == 1) ? {1'b1, 32'hFFFFFFFF} : {1'b0, 32'd5}));
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;

        // Reset in the middle of a DIV issued by req0 (so without reset req1 would win next).
        req0_valid = 1'b1; req0_a = 32'd15; req0_b = 32'd3; req0_op = 4'h3;
        wait_ready(0);
        step();
        req0_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("reset_mid_exec", all_outs(), 128'(0));
        for (int i = 0; i < 6; i++) begin
            chk("no_rsp_after_reset", 128'(rsp_valid), 128'(0));
            step();
        end
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_op = 4'h0;
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd3; req1_op = 4'h0;
        #1;
        chk("first_grant_after_reset", 128'({req0_ready, req1_ready}), 128'(2'b10));
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        // Reset while the response is waiting: it must vanish.
        wait_rsp();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("reset_mid_resp", all_outs(), 128'(0));
        for (int i = 0; i < 4; i++) begin
            chk("no_rsp_after_reset2", 128'(rsp_valid), 128'(0));
            step();
        end

        // Randomized traffic against a transaction-level model.
        do_reset();
        begin
            int   last_w   = 1;
            bit   inflight = 0;
            int   pend_acc = -1;
            bit   pend_rsp = 0;
            bit   exp_rv;
            int   g;
            cur = '{0, 1'b0, '0, '0, '0, '0, 0, 0};
            for (int c = 0; c < 1500; c++) begin
                step();
                if (pend_rsp) inflight = 0;
                if (pend_acc >= 0) begin
                    inflight = 1;
                    last_w = pend_acc;
                    cur.id = pend_acc;
                    cur.a  = (pend_acc == 1) ? req1_a  : req0_a;
                    cur.b  = (pend_acc == 1) ? req1_b  : req0_b;
                    cur.op = (pend_acc == 1) ? req1_op : req0_op;
                    cur.legal = (cur.op < 4'hC);
                    cur.o   = cur.legal ? alu_fn(cur.a, cur.b, cur.op) : '0;
                    cur.lat = !cur.legal ? 0 : ((cur.op == 4'h2 || cur.op == 4'h3) ? LAT_SLOW : LAT_FAST);
                    cur.acc = cyc;
                    if (cur.legal) begin
                        ea = cur.a; eb = cur.b; eop = cur.op;
                    end
                    if (pend_acc == 1) req1_valid = 1'b0;
                    else req0_valid = 1'b0;
                end
                pend_acc = -1;
                pend_rsp = 0;
                exp_rv = inflight && (cyc >= cur.acc + cur.lat);
                chk("rnd_valid_busy", 128'({rsp_valid, busy}), 128'({exp_rv, inflight}));
                if (exp_rv && rsp_valid)
                    chk("rnd_rsp", rsp_pack(),
                        128'({cur.id[0], cur.o.result, cur.o.hi, cur.o.lo, cur.o.nzvc, !cur.legal}));
                chk("rnd_alu_ports", 128'({alu_a, alu_b, alu_op}), 128'({ea, eb, eop}));

                if (req0_valid) begin
                    if ($urandom_range(15) == 0) req0_valid = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    req0_valid = 1'b1; req0_a = rnd_word(); req0_b = rnd_word(); req0_op = 4'($urandom_range(15));
                end
                if (req1_valid) begin
                    if ($urandom_range(15) == 0) req1_valid = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    req1_valid = 1'b1; req1_a = rnd_word(); req1_b = rnd_word(); req1_op = 4'($urandom_range(15));
                end
                rsp_ready = ($urandom_range(3) != 0);
                #1;

                g = -1;
                if (!inflight) begin
                    if (req0_valid && req1_valid) g = 1 - last_w;
                    else if (req0_valid) g = 0;
                    else if (req1_valid) g = 1;
                end
                chk("rnd_ready", 128'({req0_ready, req1_ready}), 128'({g == 0, g == 1}));
                pend_acc = g;
                pend_rsp = exp_rv && rsp_ready;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one alu32 datapath between two requesters using round-robin arbitration.
- Accepts an operation over a valid/ready request port, then drives the ALU operands and opcode and holds them stable for a per-opcode latency.
- Captures the result, multiply halves and NZVC flags, and returns them on a single valid/ready response channel tagged with the requester ID.
- Sits between the ALU and its clients: the issue stage and a secondary/debug port.

Parameters:
- LAT_FAST, 1, cycles ALU inputs are held before capture for single-cycle ops (ADD..COMP except MUL/DIV); must be >= 1.
- LAT_SLOW, 4, cycles held before capture for MUL (4'b0010) and DIV (4'b0011); must be >= 1.
- CNT_W, 4, width of the latency counter; must hold max(LAT_FAST, LAT_SLOW).

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- req0_valid  input  1  requester 0 has an op
- req0_ready  output  1  requester 0 accepted this cycle
- req0_a  input  32  operand A
- req0_b  input  32  operand B
- req0_op  input  4  ALU opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0
- alu_a  output  32  to ALU A
- alu_b  output  32  to ALU B
- alu_op  output  4  to ALU op
- alu_result  input  32  ALU result
- alu_mul_hi  input  32  ALU mul_hi
- alu_mul_lo  input  32  ALU mul_lo
- alu_nzvc  input  4  ALU {N,Z,V,C}
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that issued the op
- rsp_result  output  32  captured result
- rsp_mul_hi  output  32  captured mul_hi
- rsp_mul_lo  output  32  captured mul_lo
- rsp_nzvc  output  4  captured flags
- rsp_err  output  1  illegal opcode (4'b1100..4'b1111)
- busy  output  1  state != IDLE

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, last_grant=1 (req0 wins the first tie), counter=0.
  - All outputs 0: alu_a/b/op, rsp_*, busy. Both reqX_ready are 0 while rst=1.
  - Reset mid-EXEC or mid-RESP discards the op; no response is issued.
- States: IDLE, EXEC, RESP.
- IDLE, grant logic (combinational):
  - Only req0_valid: grant 0. Only req1_valid: grant 1.
  - Both valid: grant the one not equal to last_grant.
  - reqX_ready=1 only for the granted requester, only in IDLE; the handshake completes at valid & ready.
- On the handshake:
  - Latch a/b/op into alu_a/alu_b/alu_op and record rsp_id; last_grant <= granted id.
  - Legal op: load counter with LAT_SLOW if op is 0010 or 0011, else LAT_FAST; go to EXEC.
  - Illegal op: ALU outputs stay at the previous value; rsp_result/hi/lo=0, rsp_nzvc=0, rsp_err=1; go directly to RESP (one cycle after accept).
- EXEC:
  - alu_a/b/op held constant. Counter decrements each cycle.
  - When counter==1: capture alu_result, alu_mul_hi, alu_mul_lo, alu_nzvc into rsp_*, rsp_err=0; go to RESP.
  - Accept-to-rsp_valid latency = LAT cycles (legal), 1 cycle (illegal).
- RESP:
  - rsp_valid=1; all rsp_* held stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid drops next cycle, go to IDLE. No new request is accepted in the same cycle (minimum 1 IDLE cycle between ops).
- ALU outputs retain their last values in IDLE; no X propagation.
- Requests are not buffered. A requester must hold valid and payload stable until ready. Dropping valid before ready is allowed and simply cancels the request.
- Only one op is in flight at a time.

Test Plan:
- req0 ADD A=10 B=5, rsp_ready=1 -> req0_ready pulses, rsp_valid after LAT_FAST cycles, rsp_id=0, rsp_result=15, rsp_nzvc=0000, rsp_err=0.
- req1 MUL A=10 B=5 -> rsp_valid exactly LAT_SLOW cycles after accept, rsp_mul_lo=50, rsp_mul_hi=0, alu_op held at 0010 throughout EXEC.
- Both valid every cycle (req0 SUB 10-5, req1 XOR FF00FF00^00FF00FF) -> grants alternate 0,1,0,1; results 5 and FFFFFFFF with matching rsp_id.
- req0 op=4'b1110 -> accepted, rsp_valid next cycle with rsp_err=1, rsp_result=0; ALU ports unchanged.
- COMP 5 vs 7 with rsp_ready held 0 for 5 cycles -> rsp_valid and all rsp_* stable, busy=1, req1_valid held, req1_ready stays 0 until the response drains.
- rst asserted while in EXEC of a DIV 15/3 -> next cycle all outputs 0, state IDLE, no response ever emitted; the next req0 op is granted first.
